// File: rtl/c2c_link_recovery_ctrl_pkg.sv
// Purpose: shared state encoding and cycle-count helpers for the C2C link recovery sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package c2c_pkg;

    typedef enum logic [2:0] {
        DISABLED  = 3'd0,
        RST       = 3'd1,
        WAIT_LINK = 3'd2,
        UP        = 3'd3,
        BACKOFF   = 3'd4,
        FAIL      = 3'd5
    } state_e;

    // Microseconds to c2c_aclk cycles, saturating at 32 bits.
    function automatic logic [31:0] us_to_cycles(input longint unsigned freq,
                                                 input longint unsigned us);
        longint unsigned c;
        c = (freq / 64'd1000000) * us;
        return (c > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : c[31:0];
    endfunction

    // Backoff for attempt n: base << (n-1), saturating at 32 bits.
    function automatic logic [31:0] backoff_cycles(input logic [31:0] base,
                                                   input logic [3:0]  n);
        logic [47:0] w;
        w = {16'd0, base} << ((n == 4'd0) ? 4'd0 : (n - 4'd1));
        return (|w[47:32]) ? 32'hFFFF_FFFF : w[31:0];
    endfunction

endpackage

// File: rtl/c2c_link_recovery_ctrl_if.sv
// Purpose: bridge status, software control and status/counter bundle for the recovery sequencer.
// Latency: n/a (wires only).
// Backpressure: none; all signals are levels or single-cycle pulses.
interface c2c_link_recovery_ctrl_if;
    logic        c2c_link_status;
    logic        c2c_link_error;
    logic        c2c_multi_bit_error;
    logic        c2c_config_error;
    logic        c2c_master;
    logic        sw_enable;
    logic        sw_retry;
    logic        c2c_aresetn_out;
    logic        link_up;
    logic        fail;
    logic [3:0]  retry_cnt;
    logic [15:0] link_drop_cnt;
    logic [2:0]  state_dbg;

    // Environment side: bridge status and software drive, status is observed.
    modport master (
        output c2c_link_status, c2c_link_error, c2c_multi_bit_error, c2c_config_error,
               c2c_master, sw_enable, sw_retry,
        input  c2c_aresetn_out, link_up, fail, retry_cnt, link_drop_cnt, state_dbg
    );

    // Sequencer side.
    modport slave (
        input  c2c_link_status, c2c_link_error, c2c_multi_bit_error, c2c_config_error,
               c2c_master, sw_enable, sw_retry,
        output c2c_aresetn_out, link_up, fail, retry_cnt, link_drop_cnt, state_dbg
    );
endinterface

// File: rtl/c2c_link_recovery_ctrl_debounce.sv
// Purpose: reports a level that has been high for N consecutive sampled cycles.
// Latency: stable_hi is combinational on the N-th consecutive high sample.
// Backpressure: none; clr forces the run count back to zero.
module c2c_debounce #(
    parameter int N = 16
) (
    input  logic clk,
    input  logic rst,        // asynchronous, active-low
    input  logic clr,
    input  logic in,
    output logic stable_hi
);
    localparam int          W    = $clog2(N + 1);
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt;

    // Count prior consecutive high samples, capped at N-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || !in) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + W'(1);
        end
    end

    assign stable_hi = in && (cnt == LAST);
endmodule

// File: rtl/c2c_link_recovery_ctrl.sv
// Purpose: resets the C2C core, waits for debounced link-up, retries with exponential backoff, latches FAIL.
// Latency: all outputs registered, decoded from the next state so they move on the same edge as the state.
// Backpressure: none; sw_enable low overrides everything, sw_retry is only honoured in FAIL.
module c2c_link_recovery_ctrl
    import c2c_pkg::*;
#(
    parameter int FREQ            = 188000000,
    parameter int RST_CYCLES      = 8,
    parameter int LINK_TIMEOUT_US = 1000,
    parameter int BACKOFF_BASE_US = 100,
    parameter int MAX_RETRY       = 4,
    parameter int DEBOUNCE        = 16
) (
    input  logic                     c2c_aclk,
    input  logic                     c2c_aresetn,
    c2c_link_recovery_ctrl_if.slave  bus
);
    localparam logic [31:0] TIMEOUT   = us_to_cycles(longint'(FREQ), longint'(LINK_TIMEOUT_US));
    localparam logic [31:0] BO_BASE   = us_to_cycles(longint'(FREQ), longint'(BACKOFF_BASE_US));
    localparam logic [31:0] RST_LAST  = 32'(RST_CYCLES - 1);
    localparam logic [31:0] TO_LAST   = TIMEOUT - 32'd1;
    localparam logic [3:0]  MAX4      = 4'(MAX_RETRY);

    state_e      state, state_nxt;
    logic [31:0] tmr;
    logic [31:0] bo_cyc;
    logic [3:0]  retry_q, retry_nxt;
    logic [15:0] drop_q, drop_nxt;
    logic        aro_q, up_q, fail_q;
    logic        err, deb_hi, fail_path;

    assign err    = bus.c2c_link_error | bus.c2c_multi_bit_error | bus.c2c_config_error;
    assign bo_cyc = backoff_cycles(BO_BASE, retry_q);

    // Debounce only runs while waiting for the link; any other state holds it cleared.
    c2c_debounce #(.N(DEBOUNCE)) u_deb (
        .clk       (c2c_aclk),
        .rst       (c2c_aresetn),
        .clr       (state != WAIT_LINK),
        .in        (bus.c2c_link_status),
        .stable_hi (deb_hi)
    );

    // Next-state and counter-update decode; first matching rule wins.
    always_comb begin
        state_nxt = state;
        retry_nxt = retry_q;
        drop_nxt  = drop_q;
        fail_path = 1'b0;
        if (!bus.sw_enable) begin
            state_nxt = DISABLED;
        end else begin
            case (state)
                DISABLED: begin
                    state_nxt = RST;
                    retry_nxt = '0;
                end
                RST: if (tmr == RST_LAST) state_nxt = WAIT_LINK;
                WAIT_LINK: begin
                    if (err) begin
                        fail_path = 1'b1;
                    end else if (deb_hi) begin
                        state_nxt = UP;
                        retry_nxt = '0;
                    end else if (bus.c2c_master && (tmr >= TO_LAST)) begin
                        fail_path = 1'b1;
                    end
                end
                UP: begin
                    if (!bus.c2c_link_status || err) begin
                        state_nxt = RST;
                        retry_nxt = '0;
                        drop_nxt  = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
                    end
                end
                BACKOFF: if (tmr >= bo_cyc - 32'd1) state_nxt = RST;
                FAIL: begin
                    if (bus.sw_retry) begin
                        state_nxt = RST;
                        retry_nxt = '0;
                    end
                end
                default: state_nxt = DISABLED;
            endcase
            if (fail_path) begin
                if (retry_q + 4'd1 == MAX4) begin
                    state_nxt = FAIL;
                    retry_nxt = MAX4;
                end else begin
                    state_nxt = BACKOFF;
                    retry_nxt = retry_q + 4'd1;
                end
            end
        end
    end

    // State, timer, counters and outputs registered together.
    always_ff @(posedge c2c_aclk or negedge c2c_aresetn) begin
        if (!c2c_aresetn) begin
            state   <= DISABLED;
            tmr     <= '0;
            retry_q <= '0;
            drop_q  <= '0;
            aro_q   <= 1'b0;
            up_q    <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            retry_q <= retry_nxt;
            drop_q  <= drop_nxt;
            if (state_nxt != state)      tmr <= '0;
            else if (tmr != 32'hFFFF_FFFF) tmr <= tmr + 32'd1;
            aro_q   <= (state_nxt == WAIT_LINK) || (state_nxt == UP);
            up_q    <= (state_nxt == UP);
            fail_q  <= (state_nxt == FAIL);
        end
    end

    assign bus.c2c_aresetn_out = aro_q;
    assign bus.link_up         = up_q;
    assign bus.fail            = fail_q;
    assign bus.retry_cnt       = retry_q;
    assign bus.link_drop_cnt   = drop_q;
    assign bus.state_dbg       = state;
endmodule

// File: tb/tb_c2c_link_recovery_ctrl.sv
// Purpose: directed table-driven bench for the C2C link recovery sequencer plus multi-cycle corner sequences.
// Latency: each row holds its inputs for a number of edges, then compares all outputs 1 time unit later.
// Backpressure: n/a.
module tb_c2c_link_recovery_ctrl;

    logic c2c_aclk = 1'b0;
    logic rst_n    = 1'b0;
    int   total    = 0;
    int   bad      = 0;

    c2c_link_recovery_ctrl_if bus();

    c2c_link_recovery_ctrl #(
        .FREQ(10000000), .RST_CYCLES(8), .LINK_TIMEOUT_US(2),
        .BACKOFF_BASE_US(1), .MAX_RETRY(2), .DEBOUNCE(4)
    ) dut (
        .c2c_aclk    (c2c_aclk),
        .c2c_aresetn (rst_n),
        .bus         (bus)
    );

    always #5 c2c_aclk = ~c2c_aclk;

    // expected = {aresetn_out, link_up, fail, retry_cnt[3:0], link_drop_cnt[15:0], state[2:0]}
    typedef struct {
        string       name;
        logic        en, ls, er, ms, rt;
        int          cyc;
        logic [25:0] exp;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(string n, logic en, logic ls, logic er, logic ms, logic rt, int cyc,
                                logic aro, logic lu, logic fl, logic [3:0] rc, logic [15:0] dr,
                                logic [2:0] st);
        vec_t v;
        v.name = n; v.en = en; v.ls = ls; v.er = er; v.ms = ms; v.rt = rt; v.cyc = cyc;
        v.exp  = {aro, lu, fl, rc, dr, st};
        return v;
    endfunction

    function automatic logic [25:0] obs();
        return {bus.c2c_aresetn_out, bus.link_up, bus.fail, bus.retry_cnt,
                bus.link_drop_cnt, bus.state_dbg};
    endfunction

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge c2c_aclk);
        #1;
    endtask

    task automatic wait_st(input logic [2:0] s, input int budget, input string n);
        int k = 0;
        while (bus.state_dbg !== s && k < budget) begin
            step(1);
            k++;
        end
        chk(n, 32'(bus.state_dbg), 32'(s));
    endtask

    initial begin
        // name, en ls er ms rt cyc | aro lu fl rc drop st
        vq.push_back(mk("dis",          0,0,0,1,0,   2, 0,0,0,4'd0,16'd0,3'd0));
        vq.push_back(mk("rst_entry",    1,0,0,1,0,   1, 0,0,0,4'd0,16'd0,3'd1));
        vq.push_back(mk("rst_hold7",    1,0,0,1,0,   7, 0,0,0,4'd0,16'd0,3'd1));
        vq.push_back(mk("wait_entry",   1,0,0,1,0,   1, 1,0,0,4'd0,16'd0,3'd2));
        vq.push_back(mk("wait_low3",    1,0,0,1,0,   3, 1,0,0,4'd0,16'd0,3'd2));
        vq.push_back(mk("deb_3",        1,1,0,1,0,   3, 1,0,0,4'd0,16'd0,3'd2));
        vq.push_back(mk("up",           1,1,0,1,0,   1, 1,1,0,4'd0,16'd0,3'd3));
        vq.push_back(mk("up_hold",      1,1,0,1,0,   5, 1,1,0,4'd0,16'd0,3'd3));
        vq.push_back(mk("drop1",        1,0,0,1,0,   1, 0,0,0,4'd0,16'd1,3'd1));
        vq.push_back(mk("drop1_rst7",   1,1,0,1,0,   7, 0,0,0,4'd0,16'd1,3'd1));
        vq.push_back(mk("rewait",       1,1,0,1,0,   1, 1,0,0,4'd0,16'd1,3'd2));
        vq.push_back(mk("rewait_deb3",  1,1,0,1,0,   3, 1,0,0,4'd0,16'd1,3'd2));
        vq.push_back(mk("reup",         1,1,0,1,0,   1, 1,1,0,4'd0,16'd1,3'd3));
        vq.push_back(mk("drop2",        1,0,0,1,0,   1, 0,0,0,4'd0,16'd2,3'd1));
        vq.push_back(mk("drop2_wait",   1,0,0,1,0,   8, 1,0,0,4'd0,16'd2,3'd2));
        vq.push_back(mk("glitch_hi3",   1,1,0,1,0,   3, 1,0,0,4'd0,16'd2,3'd2));
        vq.push_back(mk("glitch_lo",    1,0,0,1,0,   1, 1,0,0,4'd0,16'd2,3'd2));
        vq.push_back(mk("glitch_hi3b",  1,1,0,1,0,   3, 1,0,0,4'd0,16'd2,3'd2));
        vq.push_back(mk("glitch_up",    1,1,0,1,0,   1, 1,1,0,4'd0,16'd2,3'd3));
        vq.push_back(mk("drop3",        1,0,0,1,0,   1, 0,0,0,4'd0,16'd3,3'd1));
        vq.push_back(mk("drop3_wait",   1,0,0,1,0,   8, 1,0,0,4'd0,16'd3,3'd2));
        vq.push_back(mk("err_deb_hi3",  1,1,0,1,0,   3, 1,0,0,4'd0,16'd3,3'd2));
        vq.push_back(mk("err_wins",     1,1,1,1,0,   1, 0,0,0,4'd1,16'd3,3'd4));
        vq.push_back(mk("bo_hold8",     1,0,0,1,0,   8, 0,0,0,4'd1,16'd3,3'd4));
        vq.push_back(mk("bo_retry_ign", 1,0,0,1,1,   1, 0,0,0,4'd1,16'd3,3'd4));
        vq.push_back(mk("bo_done",      1,0,0,1,0,   1, 0,0,0,4'd1,16'd3,3'd1));
        vq.push_back(mk("bo_rst7",      1,0,0,1,0,   7, 0,0,0,4'd1,16'd3,3'd1));
        vq.push_back(mk("bo_wait",      1,0,0,1,0,   1, 1,0,0,4'd1,16'd3,3'd2));
        vq.push_back(mk("wait19",       1,0,0,1,0,  19, 1,0,0,4'd1,16'd3,3'd2));
        vq.push_back(mk("fail",         1,0,0,1,0,   1, 0,0,1,4'd2,16'd3,3'd5));
        vq.push_back(mk("fail_hold",    1,0,0,1,0,   5, 0,0,1,4'd2,16'd3,3'd5));
        vq.push_back(mk("sw_retry",     1,0,0,1,1,   1, 0,0,0,4'd0,16'd3,3'd1));
        vq.push_back(mk("sr_rst7",      1,0,0,1,0,   7, 0,0,0,4'd0,16'd3,3'd1));
        vq.push_back(mk("sr_wait",      1,0,0,1,0,   1, 1,0,0,4'd0,16'd3,3'd2));
        vq.push_back(mk("t1_wait19",    1,0,0,1,0,  19, 1,0,0,4'd0,16'd3,3'd2));
        vq.push_back(mk("t1_bo",        1,0,0,1,0,   1, 0,0,0,4'd1,16'd3,3'd4));
        vq.push_back(mk("t1_bo9",       1,0,0,1,0,   9, 0,0,0,4'd1,16'd3,3'd4));
        vq.push_back(mk("t1_rst",       1,0,0,1,0,   1, 0,0,0,4'd1,16'd3,3'd1));
        vq.push_back(mk("t1_rst7",      1,0,0,1,0,   7, 0,0,0,4'd1,16'd3,3'd1));
        vq.push_back(mk("t2_wait",      1,0,0,1,0,   1, 1,0,0,4'd1,16'd3,3'd2));
        vq.push_back(mk("t2_wait19",    1,0,0,1,0,  19, 1,0,0,4'd1,16'd3,3'd2));
        vq.push_back(mk("t2_fail",      1,0,0,1,0,   1, 0,0,1,4'd2,16'd3,3'd5));
        vq.push_back(mk("dis_in_fail",  0,0,0,1,0,   1, 0,0,0,4'd2,16'd3,3'd0));
        vq.push_back(mk("slv_rst",      1,0,0,0,0,   1, 0,0,0,4'd0,16'd3,3'd1));
        vq.push_back(mk("slv_rst7",     1,0,0,0,0,   7, 0,0,0,4'd0,16'd3,3'd1));
        vq.push_back(mk("slv_wait",     1,0,0,0,0,   1, 1,0,0,4'd0,16'd3,3'd2));
        vq.push_back(mk("slv_1000",     1,0,0,0,0,1000, 1,0,0,4'd0,16'd3,3'd2));
        vq.push_back(mk("slv_dis",      0,0,0,0,0,   1, 0,0,0,4'd0,16'd3,3'd0));
        vq.push_back(mk("mr_rst",       1,0,0,1,0,   1, 0,0,0,4'd0,16'd3,3'd1));
        vq.push_back(mk("mr_rst3",      1,0,0,1,0,   3, 0,0,0,4'd0,16'd3,3'd1));
        vq.push_back(mk("mr_dis",       0,0,0,1,0,   1, 0,0,0,4'd0,16'd3,3'd0));
        vq.push_back(mk("mr_dis_hold",  0,0,0,1,0,   3, 0,0,0,4'd0,16'd3,3'd0));

        bus.c2c_link_status     = 1'b0;
        bus.c2c_link_error      = 1'b0;
        bus.c2c_multi_bit_error = 1'b0;
        bus.c2c_config_error    = 1'b0;
        bus.c2c_master          = 1'b1;
        bus.sw_enable           = 1'b0;
        bus.sw_retry            = 1'b0;

        #12;
        chk("reset_state", 32'(obs()), 32'd0);
        rst_n = 1'b1;
        step(1);

        for (int i = 0; i < vq.size(); i++) begin
            bus.sw_enable           = vq[i].en;
            bus.c2c_link_status     = vq[i].ls;
            bus.c2c_multi_bit_error = vq[i].er;
            bus.c2c_master          = vq[i].ms;
            bus.sw_retry            = vq[i].rt;
            step(vq[i].cyc);
            chk(vq[i].name, 32'(obs()), 32'(vq[i].exp));
        end

        // Drop counter saturation: preload just below the ceiling, then drop twice.
        bus.sw_retry        = 1'b0;
        bus.c2c_master      = 1'b1;
        bus.sw_enable       = 1'b1;
        bus.c2c_link_status = 1'b1;
        wait_st(3'd3, 40, "sat_up1");
        force dut.drop_q = 16'hFFFE;
        step(1);
        release dut.drop_q;
        bus.c2c_link_error = 1'b1;
        step(1);
        chk("sat_drop_ffff", 32'(bus.link_drop_cnt), 32'h0000FFFF);
        chk("sat_err_to_rst", 32'(bus.state_dbg), 32'd1);
        bus.c2c_link_error = 1'b0;
        wait_st(3'd3, 40, "sat_up2");
        bus.c2c_link_status = 1'b0;
        step(1);
        chk("sat_hold_ffff", 32'(bus.link_drop_cnt), 32'h0000FFFF);

        // Config error into BACKOFF, then asynchronous reset between edges.
        wait_st(3'd2, 20, "cfg_wait");
        bus.c2c_config_error = 1'b1;
        step(1);
        chk("cfg_backoff", 32'(bus.state_dbg), 32'd4);
        chk("cfg_retry1", 32'(bus.retry_cnt), 32'd1);
        bus.c2c_config_error = 1'b0;
        step(3);
        @(negedge c2c_aclk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(bus.state_dbg), 32'd0);
        chk("arst_retry", 32'(bus.retry_cnt), 32'd0);
        chk("arst_drop", 32'(bus.link_drop_cnt), 32'd0);
        chk("arst_outs", 32'({bus.c2c_aresetn_out, bus.link_up, bus.fail}), 32'd0);
        step(1);
        chk("arst_held", 32'(obs()), 32'd0);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
